// File: rtl/rs_driver.sv
// Pulse driver for an external RS latch. Issues a PW-cycle S or R pulse per
// command, lets the latch settle, then checks Q/NQ against the commanded
// value. After reset it first clears the latch with an R pulse.
module rs_driver #(
  parameter int PW     = 2,  // S/R pulse width in cycles (1..15)
  parameter int SETTLE = 1   // idle cycles between pulse end and readback (0..15)
) (
  input  logic CLK,
  input  logic NRST,
  input  logic VALID,
  input  logic OP,
  output logic READY,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic NQ,
  output logic DONE,
  output logic ERR,
  output logic QEXP
);

  typedef enum logic [2:0] {INIT, IDLE, PULSE, WAIT, CHECK} state_t;

  // Counter reload values; a single 4-bit down-counter serves both phases.
  localparam logic [3:0] PW_LD  = 4'(PW - 1);
  localparam logic [3:0] SET_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t     state;
  logic [3:0] cnt;
  logic       in_init;  // current sequence is the post-reset clear, no DONE

  // Single FSM with registered drive, handshake and status outputs.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state   <= INIT;
      cnt     <= 4'd0;
      in_init <= 1'b1;
      S       <= 1'b0;
      R       <= 1'b0;
      READY   <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      QEXP    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        INIT: begin
          // Force the latch to a known cleared state.
          in_init <= 1'b1;
          QEXP    <= 1'b0;
          S       <= 1'b0;
          R       <= 1'b1;
          cnt     <= PW_LD;
          state   <= PULSE;
        end
        IDLE: begin
          if (VALID) begin
            READY <= 1'b0;
            QEXP  <= OP;
            S     <= OP;
            R     <= ~OP;
            cnt   <= PW_LD;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == 4'd0) begin
            S <= 1'b0;
            R <= 1'b0;
            if (SETTLE == 0) begin
              state <= CHECK;
              DONE  <= ~in_init;
            end else begin
              cnt   <= SET_LD;
              state <= WAIT;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= CHECK;
            DONE  <= ~in_init;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          // Q==NQ in either polarity fails one of the two compares.
          if ((Q != QEXP) || (NQ != ~QEXP)) ERR <= 1'b1;
          in_init <= 1'b0;
          READY   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_driver.sv
// Bench for rs_driver with a cross-coupled NOR latch model on S/R/Q/NQ.
// Expected outputs come from a timeline model: each sequence starts at an
// edge k, and every output is a function of the cycle offset from k.
module tb_rs_driver;
  localparam int PW     = 2;
  localparam int SETTLE = 1;
  localparam int L      = PW + SETTLE + 1;  // command latency

  logic clk = 1'b0;
  logic nrst, valid, op;
  logic ready, s, r, done, err, qexp;
  logic q_l = 1'b0, nq_l = 1'b1;  // latch starts in the cleared state
  logic stuck0 = 1'b0;
  logic q_in, nq_in;

  rs_driver #(.PW(PW), .SETTLE(SETTLE)) dut (
    .CLK(clk), .NRST(nrst), .VALID(valid), .OP(op), .READY(ready),
    .S(s), .R(r), .Q(q_in), .NQ(nq_in), .DONE(done), .ERR(err), .QEXP(qexp)
  );

  always #5 clk = ~clk;

  // Cross-coupled NOR latch, 1 ns gate delay.
  always @(r or nq_l) q_l  <= #1 ~(r | nq_l);
  always @(s or q_l)  nq_l <= #1 ~(s | q_l);
  assign q_in  = stuck0 ? 1'b0 : q_l;
  assign nq_in = nq_l;

  int checks = 0, errors = 0;
  // Timeline model state.
  int t, k, n_acc, n_done;
  bit cmd_mode, m_op, m_qexp, m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; k = 1; cmd_mode = 0; m_qexp = 0; m_err = 0;
  endtask

  // One clock: advance model across the edge, then check all outputs.
  task automatic step(output bit acc);
    bit ready_b, chk_edge, qs, nqs, es, er;
    int p;
    ready_b  = (t - k) >= L;
    chk_edge = (t + 1 - k) == L;
    qs = q_in; nqs = nq_in;
    @(posedge clk);
    t++;
    acc = 0;
    if (chk_edge && ((qs != m_qexp) || (nqs != !m_qexp))) m_err = 1;
    if (valid && ready_b) begin
      acc = 1; k = t; cmd_mode = 1; m_op = op; m_qexp = op; n_acc++;
    end
    @(negedge clk);
    p  = t - k;
    es = cmd_mode && m_op && p >= 0 && p < PW;
    er = (!cmd_mode || !m_op) && p >= 0 && p < PW;
    chk("s", s, es);
    chk("r", r, er);
    chk("s_and_r", s & r, 0);
    chk("ready", ready, p >= L);
    chk("done", done, cmd_mode && p == PW + SETTLE);
    chk("qexp", qexp, m_qexp);
    chk("err", err, m_err);
    if (done) n_done++;
  endtask

  task automatic run(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  // Present a command after 'gap' idle cycles; hold VALID until accepted.
  task automatic command(input bit o, input int gap);
    bit a;
    int w;
    valid = 0;
    run(gap);
    valid = 1; op = o; a = 0; w = 0;
    while (!a && w < 20) begin step(a); w++; end
    chk("accept_timeout", a, 1);
    valid = 0;
  endtask

  task automatic do_reset(input int hold);
    nrst = 0; valid = 0; op = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    nrst = 1;
    model_reset();
  endtask

  initial begin
    n_acc = 0; n_done = 0;
    nrst = 0; valid = 0; op = 0;
    model_reset();
    #2;
    chk("rst_s", s, 0); chk("rst_r", r, 0); chk("rst_ready", ready, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_qexp", qexp, 0);

    // Post-reset clear sequence, READY after edge PW+SETTLE+2.
    do_reset(3);
    run(L + 2);
    chk("init_q", q_in, 0); chk("init_nq", nq_in, 1);
    chk("init_no_done", n_done, 0);

    // Set command.
    command(1, 0);
    run(L);
    chk("set_q", q_in, 1); chk("set_nq", nq_in, 0);

    // Clear held while busy: accepted only at the first READY edge.
    valid = 1; op = 1;
    begin bit a; step(a); chk("set2_acc", a, 1); end
    op = 0;
    command(0, 0);
    run(L);
    chk("clr_q", q_in, 0);
    chk("one_done_each", n_done, n_acc);

    // Same value again still runs the full sequence.
    command(0, 1);
    run(L);
    chk("repeat_done", n_done, n_acc);

    // Stuck-at-0 Q: ERR sticks through a later good clear.
    stuck0 = 1;
    command(1, 0);
    run(L);
    chk("stuck_err", err, 1);
    stuck0 = 0;
    command(0, 2);
    run(L);
    chk("err_sticky", err, 1);

    // Reset in the middle of a pulse: outputs drop without a clock edge.
    command(1, 0);
    #2;
    nrst = 0;
    #1;
    chk("abort_s", s, 0); chk("abort_r", r, 0); chk("abort_err", err, 0);
    chk("abort_ready", ready, 0); chk("abort_done", done, 0);
    n_acc--;  // aborted command never completes
    do_reset(2);
    run(L + 2);
    chk("reinit_q", q_in, 0); chk("reinit_nq", nq_in, 1);
    chk("reinit_err", err, 0);

    // Random commands with random gaps, some presented while busy.
    for (int i = 0; i < 200; i++) command(1'($urandom), $urandom_range(0, 6));
    run(L + 1);
    chk("rand_done_count", n_done, n_acc);
    chk("rand_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rs_driver.md
RS_DRIVER -- requirements
Module: rs_driver

Interface
REQ-001 Parameter PW, default 2, S/R pulse width in CLK cycles (legal 1..15).
REQ-002 Parameter SETTLE, default 1, idle cycles between pulse end and readback check (legal 0..15).
REQ-003 CLK  input  1  single clock, rising-edge active.
REQ-004 NRST  input  1  reset, asynchronous, active-low.
REQ-005 VALID  input  1  command valid.
REQ-006 OP  input  1  command: 1 = set latch (Q->1), 0 = clear latch (Q->0).
REQ-007 READY  output  1  driver accepts a command this cycle.
REQ-008 S  output  1  set drive to external RS latch.
REQ-009 R  output  1  reset drive to external RS latch.
REQ-010 Q  input  1  latch output readback.
REQ-011 NQ  input  1  latch complement readback.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 ERR  output  1  sticky readback-error flag.
REQ-014 QEXP  output  1  expected latch state (last commanded value).

Function
REQ-015 FSM states SHALL be INIT, IDLE, PULSE, WAIT, CHECK; S, R, READY, DONE, ERR, QEXP are registered.
REQ-016 READY SHALL be 1 only in IDLE; a command SHALL be accepted at a rising edge where VALID=1 and READY=1.
REQ-017 VALID while READY=0 SHALL be ignored (no queue); requester holds VALID until accepted.
REQ-018 On acceptance at edge k: OP captured, QEXP<=OP, state<=PULSE, S<=OP, R<=~OP at the same edge.
REQ-019 S/R SHALL stay high for exactly PW cycles (high after edges k..k+PW-1, low after edge k+PW).
REQ-020 S and R SHALL never both be 1 in any cycle, including across reset and back-to-back commands.
REQ-021 WAIT SHALL hold S=R=0 for SETTLE cycles; SETTLE=0 goes directly PULSE->CHECK.
REQ-022 CHECK lasts one cycle (after edge k+PW+SETTLE): DONE=1; mismatch if Q!=QEXP or NQ!=~QEXP.
REQ-023 Q==NQ (either value) at CHECK SHALL count as mismatch.
REQ-024 Mismatch SHALL set ERR; ERR cleared only by NRST; ERR does not block operation.
REQ-025 CHECK -> IDLE; READY=1 after edge k+PW+SETTLE+1; total command latency PW+SETTLE+1 cycles.
REQ-026 A command with OP equal to current QEXP SHALL still run the full pulse/check sequence.
REQ-027 Pulse/settle counting SHALL use a single 4-bit down-counter reloaded on each state entry.

Reset
REQ-028 NRST low SHALL immediately force S=0, R=0, READY=0, DONE=0, ERR=0, QEXP=0, state=INIT.
REQ-029 INIT: R<=1 at edge 1 after NRST release, R high PW cycles, then WAIT, then CHECK with QEXP=0.
REQ-030 INIT's CHECK SHALL update ERR per REQ-022/023 but SHALL NOT assert DONE.
REQ-031 READY SHALL first assert after edge PW+SETTLE+2 following NRST release.
REQ-032 NRST low mid-operation SHALL abort the command (no DONE) and rerun INIT on release.

Verification (PW=2, SETTLE=1, behavioural cross-coupled NOR latch with 1 ns gate delay on S/R/Q/NQ)
REQ-033 Reset release -> R=1 after edges 1,2, S=0 throughout, READY=1 after edge 5, Q=0, NQ=1, ERR=0, DONE never pulses.
REQ-034 VALID=1, OP=1 accepted at edge k -> S=1 after edges k,k+1, DONE=1 after edge k+3, Q=1, QEXP=1, ERR=0, READY=1 after edge k+4.
REQ-035 VALID=1, OP=0 held while busy -> accepted only at first READY edge, Q=0, exactly one DONE per accepted command.
REQ-036 Q forced stuck 0, command OP=1 -> ERR=1 in the cycle after the CHECK; ERR remains 1 after a subsequent good clear.
REQ-037 NRST low during PULSE -> S=R=0 with no clock edge, ERR=0, no DONE, INIT sequence repeats per REQ-033.
REQ-038 200 random commands with random VALID gaps -> S&R never 1, DONE count equals accepted count, ERR=0.
